// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back collector: per-pipe result, dispatcher write port, pipe IDs.
// Pure declarations; no latency or flow control of its own.
package wb_arbiter_pkg;

  localparam int WB_XLEN     = 32;
  localparam int WB_NUM_REGS = 32;
  localparam int RD_W        = $clog2(WB_NUM_REGS);
  localparam int NUM_FIXED   = 3;

  typedef enum logic [1:0] {
    EXE_ALU = 2'd0,
    EXE_LSU = 2'd1,
    EXE_MUL = 2'd2,
    EXE_DIV = 2'd3
  } exe_id_e;

  typedef struct packed {
    logic               valid;
    logic               rwr;
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] data;
  } exe_wb_inf_t;

  typedef struct packed {
    logic               wr_en;
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] data;
  } wb_dispatcher_inf_t;

  function automatic logic [2:0] count_ones(input logic [NUM_FIXED-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_FIXED; i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry bypassing hold register: passes input straight through when empty, parks it when output stalls.
// Latency 0 when empty, drains 1+ cycles later when full; in_ready_o drops while the entry is occupied.
module wb_hold_reg #(
  parameter int W = 37
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic         hold_valid_o
);

  logic         hold_valid_q, hold_valid_d;
  logic [W-1:0] hold_data_q, hold_data_d;

  assign in_ready_o   = ~hold_valid_q;
  assign hold_valid_o = hold_valid_q;
  assign out_valid_o  = hold_valid_q | in_valid_i;
  assign out_data_o   = hold_valid_q ? hold_data_q : in_data_i;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (hold_valid_q) begin
      if (out_ready_i) hold_valid_d = 1'b0;
    end else if (in_valid_i && !out_ready_i) begin
      // Accepted but the output slot is taken this cycle: park it.
      hold_valid_d = 1'b1;
      hold_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back collector: picks one register write per cycle from ALU > LSU > MUL, DIV fills idle slots.
// One registered stage (N -> N+1); DIV is backpressured via div_ready while its hold entry is full.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN     = WB_XLEN,
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int CNT_W    = 64,
  localparam int RDW     = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic             alu_rwr,
  input  logic [RDW-1:0]   alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  input  logic             lsu_rwr,
  input  logic [RDW-1:0]   lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             mul_valid,
  input  logic             mul_rwr,
  input  logic [RDW-1:0]   mul_rd,
  input  logic [XLEN-1:0]  mul_data,
  input  logic             div_valid,
  input  logic [RDW-1:0]   div_rd,
  input  logic [XLEN-1:0]  div_data,
  output logic             div_ready,
  output logic             wr_en,
  output logic [RDW-1:0]   wr_rd,
  output logic [XLEN-1:0]  wr_data,
  output logic             div_done,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             wb_collision
);

  localparam int DIV_W = RDW + XLEN;

  exe_wb_inf_t [NUM_FIXED-1:0] pipe;
  logic [NUM_FIXED-1:0]        valid_vec;
  logic [NUM_FIXED-1:0]        req_vec;
  logic                        fixed_req;
  exe_wb_inf_t                 sel;

  logic                        div_out_valid;
  logic [DIV_W-1:0]            div_out_data;
  logic                        div_issue;
  logic                        hold_valid;

  wb_dispatcher_inf_t          wb_q, wb_d;
  logic                        div_done_q, div_done_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        coll_q, coll_d;

  assign pipe[EXE_ALU] = '{valid: alu_valid, rwr: alu_rwr, rd: alu_rd, data: alu_data};
  assign pipe[EXE_LSU] = '{valid: lsu_valid, rwr: lsu_rwr, rd: lsu_rd, data: lsu_data};
  assign pipe[EXE_MUL] = '{valid: mul_valid, rwr: mul_rwr, rd: mul_rd, data: mul_data};

  // Walk from lowest priority up so the ALU overwrites any earlier pick.
  always_comb begin
    valid_vec = '0;
    req_vec   = '0;
    sel       = '0;
    for (int i = NUM_FIXED - 1; i >= 0; i--) begin
      valid_vec[i] = pipe[i].valid;
      req_vec[i]   = pipe[i].valid & pipe[i].rwr;
      if (req_vec[i]) sel = pipe[i];
    end
  end

  assign fixed_req = |req_vec;

  wb_hold_reg #(
    .W (DIV_W)
  ) u_div_hold (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (div_valid),
    .in_data_i    ({div_rd, div_data}),
    .in_ready_o   (div_ready),
    .out_valid_o  (div_out_valid),
    .out_data_o   (div_out_data),
    .out_ready_i  (~fixed_req),
    .hold_valid_o (hold_valid)
  );

  assign div_issue = div_out_valid & ~fixed_req;

  always_comb begin
    wb_d       = wb_q;
    wb_d.wr_en = 1'b0;
    div_done_d = 1'b0;
    if (fixed_req) begin
      wb_d.wr_en = 1'b1;
      wb_d.rd    = sel.rd;
      wb_d.data  = sel.data;
    end else if (div_issue) begin
      wb_d.wr_en = 1'b1;
      wb_d.rd    = div_out_data[DIV_W-1:XLEN];
      wb_d.data  = div_out_data[XLEN-1:0];
      div_done_d = 1'b1;
    end
    // x0 still gets a write so the scoreboard bit clears, but never non-zero data.
    if (wb_d.wr_en && wb_d.rd == '0) wb_d.data = '0;
  end

  assign cnt_d  = cnt_q + CNT_W'(count_ones(valid_vec)) + CNT_W'(div_issue);
  assign coll_d = coll_q | (count_ones(req_vec) > 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q       <= '0;
      div_done_q <= 1'b0;
      cnt_q      <= '0;
      coll_q     <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      div_done_q <= div_done_d;
      cnt_q      <= cnt_d;
      coll_q     <= coll_d;
    end
  end

  assign wr_en        = wb_q.wr_en;
  assign wr_rd        = wb_q.rd;
  assign wr_data      = wb_q.data;
  assign div_done     = div_done_q;
  assign retire_cnt   = cnt_q;
  assign wb_collision = coll_q;

  // hold_valid is exported for visibility; div_ready already reflects it.
  logic unused_hold;
  assign unused_hold = hold_valid;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, alu_rwr, lsu_valid, lsu_rwr, mul_valid, mul_rwr, div_valid;
  logic [4:0]  alu_rd, lsu_rd, mul_rd, div_rd;
  logic [31:0] alu_data, lsu_data, mul_data, div_data;
  logic        div_ready, wr_en, div_done, wb_collision;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [63:0] retire_cnt;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rwr(alu_rwr), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rwr(lsu_rwr), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mul_valid(mul_valid), .mul_rwr(mul_rwr), .mul_rd(mul_rd), .mul_data(mul_data),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data), .div_ready(div_ready),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .div_done(div_done),
    .retire_cnt(retire_cnt), .wb_collision(wb_collision)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } div_ent_t;

  div_ent_t    m_hold[$];
  logic [63:0] m_cnt;
  bit          m_coll;
  bit          div_pend;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rwr = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rwr = 0; lsu_rd = 0; lsu_data = 0;
    mul_valid = 0; mul_rwr = 0; mul_rd = 0; mul_data = 0;
    div_valid = 0; div_rd = 0; div_data = 0;
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_cnt  = 0;
    m_coll = 0;
  endtask

  // Apply the current inputs for one clock and check the result against the model.
  task automatic run_cycle(output bit acc);
    bit          v[3], w[3];
    logic [4:0]  r[3];
    logic [31:0] d[3];
    int          nval, nfix, win;
    bit          en, done;
    logic [4:0]  erd;
    logic [31:0] edat;
    div_ent_t    e;
    v = '{alu_valid, lsu_valid, mul_valid};
    w = '{alu_rwr, lsu_rwr, mul_rwr};
    r = '{alu_rd, lsu_rd, mul_rd};
    d = '{alu_data, lsu_data, mul_data};
    nval = 0; nfix = 0; win = -1;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) nval++;
      if (v[i] && w[i]) begin
        nfix++;
        if (win < 0) win = i;
      end
    end
    chk("div_ready", 64'(div_ready), 64'(m_hold.size() == 0));
    acc = div_valid && (m_hold.size() == 0);
    en = 0; done = 0; erd = 0; edat = 0;
    if (nfix > 0) begin
      en = 1; erd = r[win]; edat = d[win];
      if (acc) m_hold.push_back('{div_rd, div_data});
    end else if (m_hold.size() > 0) begin
      e = m_hold.pop_front();
      en = 1; done = 1; erd = e.rd; edat = e.data;
    end else if (acc) begin
      en = 1; done = 1; erd = div_rd; edat = div_data;
    end
    if (en && erd == 0) edat = 0;
    m_cnt = m_cnt + 64'(nval) + 64'(done);
    if (nfix > 1) m_coll = 1;
    @(posedge clk);
    #1;
    chk("wr_en", 64'(wr_en), 64'(en));
    chk("div_done", 64'(div_done), 64'(done));
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("wb_collision", 64'(wb_collision), 64'(m_coll));
    if (en) begin
      chk("wr_rd", 64'(wr_rd), 64'(erd));
      chk("wr_data", 64'(wr_data), 64'(edat));
    end
  endtask

  task automatic rand_cycle(input bit allow_coll);
    bit acc;
    alu_valid = ($urandom_range(0, 2) == 0); alu_rwr = ($urandom_range(0, 3) != 0);
    lsu_valid = ($urandom_range(0, 2) == 0); lsu_rwr = ($urandom_range(0, 3) != 0);
    mul_valid = ($urandom_range(0, 2) == 0); mul_rwr = ($urandom_range(0, 3) != 0);
    alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
    lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
    mul_rd = 5'($urandom_range(0, 31)); mul_data = $urandom;
    if (!allow_coll) begin
      if (alu_valid && alu_rwr) begin
        lsu_rwr = 0; mul_rwr = 0;
      end else if (lsu_valid && lsu_rwr) begin
        mul_rwr = 0;
      end
    end
    if (!div_pend && $urandom_range(0, 3) == 0) begin
      div_pend = 1;
      div_rd   = 5'($urandom_range(0, 31));
      div_data = $urandom;
    end
    div_valid = div_pend;
    run_cycle(acc);
    if (acc) div_pend = 0;
  endtask

  initial begin
    bit          acc;
    logic [63:0] cnt0;
    idle();
    model_reset();
    div_pend = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_div_done", 64'(div_done), 64'd0);
    chk("rst_collision", 64'(wb_collision), 64'd0);
    chk("rst_retire_cnt", retire_cnt, 64'd0);
    chk("rst_wr_rd", 64'(wr_rd), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_div_ready", 64'(div_ready), 64'd1);
    @(negedge clk);
    rst_n = 1;

    // Single ALU write
    idle();
    alu_valid = 1; alu_rwr = 1; alu_rd = 5; alu_data = 32'h1234;
    run_cycle(acc);
    chk("alu_rd", 64'(wr_rd), 64'd5);
    chk("alu_data", 64'(wr_data), 64'h1234);
    chk("alu_cnt", retire_cnt, 64'd1);

    // DIV uncontended
    idle();
    div_valid = 1; div_rd = 7; div_data = 32'hA;
    run_cycle(acc);
    chk("div_rd", 64'(wr_rd), 64'd7);
    chk("div_done_direct", 64'(div_done), 64'd1);

    // DIV collides with MUL, then ALU keeps the slot one more cycle
    idle();
    mul_valid = 1; mul_rwr = 1; mul_rd = 3; mul_data = 9;
    div_valid = 1; div_rd = 4; div_data = 32'h55;
    run_cycle(acc);
    chk("coll_first_rd", 64'(wr_rd), 64'd3);
    chk("coll_no_done", 64'(div_done), 64'd0);
    chk("coll_hold_full", 64'(div_ready), 64'd0);
    idle();
    alu_valid = 1; alu_rwr = 1; alu_rd = 6; alu_data = 32'h66;
    run_cycle(acc);
    chk("coll_second_rd", 64'(wr_rd), 64'd6);
    idle();
    run_cycle(acc);
    chk("coll_drain_rd", 64'(wr_rd), 64'd4);
    chk("coll_drain_data", 64'(wr_data), 64'h55);
    chk("coll_drain_done", 64'(div_done), 64'd1);
    chk("coll_hold_empty", 64'(div_ready), 64'd1);

    // Store plus DIV
    idle();
    cnt0 = m_cnt;
    lsu_valid = 1; lsu_rwr = 0; lsu_rd = 9; lsu_data = 32'h99;
    div_valid = 1; div_rd = 8; div_data = 32'h88;
    run_cycle(acc);
    chk("store_div_rd", 64'(wr_rd), 64'd8);
    chk("store_div_done", 64'(div_done), 64'd1);
    chk("store_div_cnt", retire_cnt, cnt0 + 64'd2);

    // Write to x0
    idle();
    alu_valid = 1; alu_rwr = 1; alu_rd = 0; alu_data = 32'hFFFF;
    run_cycle(acc);
    chk("x0_wr_en", 64'(wr_en), 64'd1);
    chk("x0_data", 64'(wr_data), 64'd0);

    idle();
    for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
    chk("no_coll_yet", 64'(wb_collision), 64'd0);

    // Let any pending DIV offer finish, then force a two-writer collision
    idle();
    div_valid = div_pend;
    while (div_pend) begin
      run_cycle(acc);
      if (acc) div_pend = 0;
      div_valid = div_pend;
    end
    idle();
    repeat (2) run_cycle(acc);
    alu_valid = 1; alu_rwr = 1; alu_rd = 10; alu_data = 32'h1;
    lsu_valid = 1; lsu_rwr = 1; lsu_rd = 11; lsu_data = 32'h2;
    run_cycle(acc);
    chk("coll_winner", 64'(wr_rd), 64'd10);
    chk("coll_flag", 64'(wb_collision), 64'd1);
    idle();
    repeat (3) run_cycle(acc);
    chk("coll_sticky", 64'(wb_collision), 64'd1);

    for (int i = 0; i < 500; i++) rand_cycle(1'b1);

    // Reset while a DIV entry is held
    idle();
    div_pend = 0;
    repeat (2) run_cycle(acc);
    mul_valid = 1; mul_rwr = 1; mul_rd = 3; mul_data = 32'h3;
    div_valid = 1; div_rd = 4; div_data = 32'h44;
    run_cycle(acc);
    idle();
    chk("pre_rst_held", 64'(div_ready), 64'd0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_div_ready", 64'(div_ready), 64'd1);
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_div_done", 64'(div_done), 64'd0);
    chk("mid_rst_cnt", retire_cnt, 64'd0);
    chk("mid_rst_collision", 64'(wb_collision), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    run_cycle(acc);
    chk("post_rst_no_done", 64'(div_done), 64'd0);
    run_cycle(acc);
    chk("post_rst_cnt", retire_cnt, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back collector: the producer side of the dispatcher's write-back interface.
- Gathers results from the ALU, LSU, MUL and DIV pipes and picks at most one register write per cycle.
- Drives that write to the dispatcher as wr_en/rd/wr_data. The same write updates the register file and clears the scoreboard.
- Holds a DIV result that collides with a fixed-latency result, signals division completion (div_done), and keeps the retired-instruction count.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count; RD_W = $clog2(NUM_REGS).
- CNT_W, 64, width of the retire counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_valid, lsu_valid, mul_valid  in  1 each  fixed-latency pipe result valid this cycle.
- alu_rwr, lsu_rwr, mul_rwr  in  1 each  result writes a register.
- alu_rd, lsu_rd, mul_rd  in  RD_W each  destination register.
- alu_data, lsu_data, mul_data  in  XLEN each  result data.
- div_valid  in  1  DIV result offered.
- div_rd  in  RD_W  DIV destination register.
- div_data  in  XLEN  DIV result data.
- div_ready  out  1  DIV result accepted this cycle (combinational: ~hold_valid).
- wr_en  out  1  write-back enable.
- wr_rd  out  RD_W  write-back register.
- wr_data  out  XLEN  write-back data.
- div_done  out  1  one-cycle pulse: the DIV result is on the write port this cycle.
- retire_cnt  out  CNT_W  retired-instruction count.
- wb_collision  out  1  sticky error flag.

Behaviour:
- Reset: async assert. wr_en, div_done, wb_collision = 0; hold_valid = 0; retire_cnt = 0; wr_rd and wr_data = 0.
- Latency: one registered stage. Inputs accepted at cycle N appear on the write port at N+1.
- Fixed slot: fixed_req = a valid pipe with rwr = 1.
  - Priority ALU > LSU > MUL.
  - If more than one pipe is valid with rwr = 1, the winner writes and wb_collision sets. It stays set until reset. The dispatcher guarantees this never happens.
- Fixed pipes with rwr = 0 (stores, branches) retire without using the write slot.
- DIV path, one-entry hold register:
  - Capture condition: div_valid && div_ready.
  - If fixed_req = 0 at capture, the DIV result goes straight to the output stage.
  - Otherwise it is latched into hold (hold_valid = 1, div_ready drops next cycle).
  - A held entry drains on the first cycle with fixed_req = 0; hold_valid clears the same edge.
  - Hold has priority over a new div_valid; a new offer is not accepted while hold_valid = 1.
- div_done: registered alongside wr_en. Asserted exactly in the cycle the DIV result is on wr_en, never at capture into hold.
- rd = x0: wr_en still asserts (so the scoreboard bit clears) and wr_data is forced to 0.
- Retire counter: at each edge retire_cnt += (fixed pipes valid, each counts 1) + (DIV result issued to output stage). The increment is 0..4 and wraps modulo 2^CNT_W.
- Simultaneous DIV drain and DIV capture cannot occur because div_ready = 0 while the hold is full.
- Reset mid-operation: the hold entry and any pending write are dropped; no div_done is issued.
- No flush input. Every result reaching this block belongs to a committed instruction.

Decomposition:
- Shared package:
  - exe_wb_inf_t {valid, rwr, rd, data}: per-pipe result struct.
  - wb_dispatcher_inf_t: the existing write-back struct, reused for the output.
  - RD_W.
  - EXE pipe IDs: reuse the existing constants.
- Sub-module: wb_hold_reg, the one-entry valid/ready holding register. Natural to split out and unit-test alone.
- Arbitration, output stage and counter stay in the top module.

Test Plan:
- Single ALU write: alu_valid=1, rwr=1, rd=5, data=0x1234 at N -> wr_en=1, wr_rd=5, wr_data=0x1234 at N+1; retire_cnt=1; div_done=0.
- DIV uncontended: div_valid=1, rd=7, data=0xA at N, no fixed request -> div_ready=1 at N; wr_en=1, wr_rd=7, div_done=1 at N+1.
- DIV collides with MUL:
  - Stimulus: at N, mul rd=3 data=9 and div rd=4 data=0x55; at N+1 the ALU writes rd=6.
  - Required response: N+1 writes x3; div_ready=0 at N+1; N+2 writes x6; x4 with div_done=1 at N+3; hold empty at N+3.
- Store plus DIV: at N, lsu_valid=1 with rwr=0 and div rd=8 -> N+1 writes x8 with div_done=1; retire_cnt increments by 2.
- x0 and collision:
  - alu rd=0 data=0xFFFF -> wr_en=1, wr_rd=0, wr_data=0.
  - alu and lsu both with rwr=1 -> ALU wins; wb_collision=1 and stays set.
- Reset with a held DIV entry: rst_n low then high -> hold_valid=0, div_ready=1, no div_done, retire_cnt=0.
